// File: rtl/round_pipe.sv
// Single-stage rounding pipeline: quantises a signed sample to multiples of 2^(n-p-1) and
// reports the rounding error. Define ROUND_PIPE_ERRFB_EN to add first-order error feedback.
module round_pipe #(
    parameter int unsigned n = 8,
    parameter int unsigned m = 8,
    parameter int unsigned p = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   mode,
    output logic [m-1:0] out,
    output logic [n-1:0] err,
    output logic         sat,
    output logic         out_valid,
    input  logic         out_ready
);
    localparam int unsigned QB = n - p - 1;
    localparam logic signed [n+1:0] ONE  = {{(n+1){1'b0}}, 1'b1};
    localparam logic signed [n+1:0] QV   = ONE <<< QB;
    localparam logic signed [n+1:0] HALF = ONE <<< (QB - 1);
    localparam logic signed [n+1:0] QM1  = QV - ONE;
    localparam logic signed [n+1:0] NQ   = -QV;
    localparam logic signed [n+1:0] HI   = (ONE <<< (n - 1)) - QV;
    localparam logic signed [n+1:0] LO   = -(ONE <<< (n - 1));

    logic signed [n+1:0] x, flr, hu_clr, r_raw, r_ext, e_full;
    logic [QB-1:0] frac;
    logic          tie, sat_hi, sat_lo, sat_d, accept;
    logic [n-1:0]  r_d, err_d, r_q, err_q;
    logic          sat_q, out_valid_q, out_valid_d;

    always_comb begin
`ifdef ROUND_PIPE_ERRFB_EN
        x = $signed({{2{in[n-1]}}, in}) + $signed({{2{err_q[n-1]}}, err_q});
`else
        x = $signed({{2{in[n-1]}}, in});
`endif
        frac   = x[QB-1:0];
        flr    = x & ~QM1;
        hu_clr = (x + HALF) & ~QM1;
        tie    = (frac == HALF[QB-1:0]);

        case (mode)
            2'd0:    r_raw = hu_clr;
            2'd1:    r_raw = flr;
            // Half-up lands on k+1 for a tie; step back when that multiple is odd.
            2'd2:    r_raw = (tie && hu_clr[QB]) ? hu_clr - QV : hu_clr;
            default: r_raw = (x[n+1] && (frac != '0)) ? flr + QV : flr;
        endcase

        sat_hi = (r_raw > HI);
        sat_lo = (r_raw < LO);
        sat_d  = sat_hi || sat_lo;
        r_d    = sat_hi ? HI[n-1:0] : (sat_lo ? LO[n-1:0] : r_raw[n-1:0]);
        r_ext  = $signed({{2{r_d[n-1]}}, r_d});
        e_full = x - r_ext;

        err_d = e_full[n-1:0];
        if (sat_d) begin
            if (e_full > QM1) begin
                err_d = QM1[n-1:0];
            end else if (e_full < NQ) begin
                err_d = NQ[n-1:0];
            end
        end
    end

    always_comb begin
        in_ready    = !out_valid_q || out_ready;
        accept      = in_valid && in_ready;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            r_q         <= '0;
            err_q       <= '0;
            sat_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (accept) begin
                r_q   <= r_d;
                err_q <= err_d;
                sat_q <= sat_d;
            end
        end
    end

    assign out       = r_q[n-1:n-m];
    assign err       = err_q;
    assign sat       = sat_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_round_pipe.sv
// Randomised self-checking bench for round_pipe against an arithmetic rounding model.
module tb_round_pipe;
    localparam int N = 8;
    localparam int M = 8;
    localparam int P = 2;
    localparam int Q = 1 << (N - P - 1);

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] din;
    logic         din_valid;
    logic         in_ready;
    logic [1:0]   mode;
    logic [M-1:0] dout;
    logic [N-1:0] err;
    logic         sat;
    logic         out_valid;
    logic         out_ready;

    int vectors = 0;
    int miscompares = 0;

    // Model of the visible result: rounded value, error, sat flag, valid flag.
    int m_r = 0;
    int m_e = 0;
    int m_sat = 0;
    int m_v = 0;
    int last_acc = 0;

    round_pipe #(.n(N), .m(M), .p(P)) dut (
        .clk(clk), .rst(rst), .in(din), .in_valid(din_valid), .in_ready(in_ready),
        .mode(mode), .out(dout), .err(err), .sat(sat), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    task automatic ref_round(input int x, input int md, output int r, output int e,
                             output int s);
        int k, rem, hi, lo;
        k   = fdiv(x, Q);
        rem = x - k * Q;
        case (md)
            0: r = fdiv(x + Q / 2, Q) * Q;
            1: r = k * Q;
            2: r = (rem > Q / 2 || (rem == Q / 2 && (k % 2) != 0)) ? (k + 1) * Q : k * Q;
            default: r = (x >= 0) ? k * Q : -(fdiv(-x, Q) * Q);
        endcase
        hi = (1 << (N - 1)) - Q;
        lo = -(1 << (N - 1));
        s  = 0;
        if (r > hi) begin r = hi; s = 1; end
        if (r < lo) begin r = lo; s = 1; end
        e = x - r;
        if (s != 0) begin
            if (e > Q - 1) e = Q - 1;
            if (e < -Q) e = -Q;
        end
    endtask

    task automatic cycle(input int r, input int v, input int d, input int md, input int ordy);
        int exp_rdy, x, rr, ee, ss;
        @(negedge clk);
        rst       = r[0];
        din_valid = v[0];
        din       = d[N-1:0];
        mode      = md[1:0];
        out_ready = ordy[0];
        #1;
        exp_rdy = (m_v == 0 || ordy != 0) ? 1 : 0;
        check("in_ready", int'(in_ready), exp_rdy);
        last_acc = (v != 0 && in_ready && r == 0) ? 1 : 0;
        @(posedge clk);
        if (r != 0) begin
            m_r = 0; m_e = 0; m_sat = 0; m_v = 0;
        end else if (v != 0 && exp_rdy != 0) begin
`ifdef ROUND_PIPE_ERRFB_EN
            x = d + m_e;
`else
            x = d;
`endif
            ref_round(x, md, rr, ee, ss);
            m_r = rr; m_e = ee; m_sat = ss; m_v = 1;
        end else if (ordy != 0) begin
            m_v = 0;
        end
        #1;
        check("out_valid", int'(out_valid), m_v);
        check("out", int'($signed(dout)), m_r >>> (N - M));
        check("err", int'($signed(err)), m_e);
        check("sat", int'(sat), m_sat);
    endtask

    task automatic directed(input int d, input int md, input int eo, input int ee, input int es);
        cycle(0, 1, d, md, 1);
        check("dir_valid", int'(out_valid), 1);
        check("dir_out", int'($signed(dout)), eo);
        check("dir_err", int'($signed(err)), ee);
        check("dir_sat", int'(sat), es);
    endtask

    initial begin
        int acc;
        rst = 1'b1; din_valid = 1'b0; din = '0; mode = '0; out_ready = 1'b1;
        cycle(1, 1, 5, 0, 1);
        cycle(1, 0, 0, 0, 1);
        check("rst_valid", int'(out_valid), 0);
        check("rst_out", int'($signed(dout)), 0);
        check("rst_err", int'($signed(err)), 0);

`ifndef ROUND_PIPE_ERRFB_EN
        directed(16, 0, 32, -16, 0);
        directed(16, 2, 0, 16, 0);
        directed(48, 2, 64, -16, 0);
        directed(-1, 1, -32, 31, 0);
        directed(-1, 3, 0, -1, 0);
        directed(127, 0, 96, 31, 1);
        directed(-128, 0, -128, 0, 0);
`else
        directed(16, 0, 32, -16, 0);
        directed(16, 0, 0, 0, 0);
        cycle(0, 1, 16, 0, 1);
        cycle(1, 0, 0, 0, 1);
        directed(16, 0, 32, -16, 0);
        cycle(1, 0, 0, 0, 1);
`endif

        // Back-pressure: one held result, no accepts while stalled, then streaming.
        cycle(0, 1, 40, 0, 1);
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 10 * i, 0, 0);
            check("stall_rdy", int'(in_ready), 0);
            acc += last_acc;
        end
        check("stall_acc", acc, 0);
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 20 * i - 30, i, 1);
            acc += last_acc;
        end
        check("stream_acc", acc, 4);

        // Reset while a result is held discards it.
        cycle(0, 1, 70, 1, 0);
        cycle(1, 1, 50, 0, 0);
        check("rst_stall_valid", int'(out_valid), 0);
        cycle(0, 0, 0, 0, 0);
        check("post_rst_rdy", int'(in_ready), 1);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) < 2) ? 1 : 0,
                  ($urandom_range(0, 99) < 70) ? 1 : 0,
                  int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 99) < 70) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
